// File: rtl/add_sub_serial.sv
// Serial multi-cycle adder/subtractor: SLICE bits per clock, LSB slice first, start/done handshake.
// Define ADD_SATURATE_EN to clamp Soma to signed max/min on overflow instead of wrapping.
module add_sub_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Input1,
    input  logic [WIDTH-1:0] Input2,
    input  logic             Sub,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Soma,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);
    localparam int unsigned N    = WIDTH / SLICE;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [IdxW-1:0]  idx_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] soma_q;
    logic             cout_q, ovf_q, zero_q;

    int unsigned      lsb;
    logic [SLICE-1:0] slice_a, slice_b;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] slice_mask;
    logic [WIDTH-1:0] sum_d;
    logic             overflow_d;
    logic [WIDTH-1:0] soma_d;

    always_comb begin
        lsb        = 32'(idx_q) * SLICE;
        slice_a    = SLICE'(a_q >> lsb);
        slice_b    = SLICE'(b_q >> lsb);
        slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
        slice_mask = WIDTH'({SLICE{1'b1}});
        // Splice the current slice into the partial sum; only meaningful on the last slice.
        sum_d      = (sum_q & ~(slice_mask << lsb)) | (WIDTH'(slice_sum[SLICE-1:0]) << lsb);
        overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
        soma_d     = sum_d;
`ifdef ADD_SATURATE_EN
        if (overflow_d) begin
            soma_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            soma_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        a_q     <= Input1;
                        b_q     <= Sub ? ~Input2 : Input2;
                        carry_q <= Sub;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_sum[SLICE];
                    idx_q   <= idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                        soma_q  <= soma_d;
                        cout_q  <= slice_sum[SLICE];
                        ovf_q   <= overflow_d;
                        zero_q  <= (soma_d == '0);
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Soma     = soma_q;
    assign CarryOut = cout_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial: default 32/8 instance plus a 16/16 single-slice instance.
module tb_add_sub_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] in1 = '0, in2 = '0;
    logic        sub = 1'b0, start = 1'b0;
    logic        busy, done, cout, ovf, zero;
    logic [31:0] soma;

    logic [15:0] s_in1 = '0, s_in2 = '0;
    logic        s_sub = 1'b0, s_start = 1'b0;
    logic        s_busy, s_done, s_cout, s_ovf, s_zero;
    logic [15:0] s_soma;

    add_sub_serial dut (
        .clk(clk), .reset(reset), .Input1(in1), .Input2(in2), .Sub(sub), .Start(start),
        .Busy(busy), .Done(done), .Soma(soma), .CarryOut(cout), .Overflow(ovf), .Zero(zero)
    );

    add_sub_serial #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk(clk), .reset(reset), .Input1(s_in1), .Input2(s_in2), .Sub(s_sub), .Start(s_start),
        .Busy(s_busy), .Done(s_done), .Soma(s_soma), .CarryOut(s_cout), .Overflow(s_ovf),
        .Zero(s_zero)
    );

    typedef struct packed {
        logic [31:0] soma;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    logic [31:0] corner_a[4] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] corner_b[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    logic        corner_s[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] bb;
        logic [32:0] full;
        exp_t        e;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {32'd0, s};
        e.soma = full[31:0];
        e.cout = full[32];
        e.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
`ifdef ADD_SATURATE_EN
        if (e.ovf) e.soma = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        e.zero = (e.soma == 32'd0);
        return e;
    endfunction

    // Leaves the caller just after the Start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk); #1;
        in1 = a; in2 = b; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (done) break;
            lat++;
        end
    endtask

    task automatic test_reset;
        exp_t got;
        int   busy_cnt;
        // Start held together with reset must be dropped.
        start = 1'b1; in1 = 32'd5; in2 = 32'd7;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        got = {soma, cout, ovf, zero};
        total_cnt++;
        if (got !== 35'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_state: got=%h busy=%b done=%b required all 0", got, busy, done);
        else pass_cnt++;
        busy_cnt = 0;
        repeat (4) begin @(negedge clk); busy_cnt += int'(busy); end
        total_cnt++;
        if (busy_cnt !== 0) $display("FAIL reset_start_drop: busy cycles=%0d required 0", busy_cnt);
        else pass_cnt++;
    endtask

    task automatic test_add;
        exp_t got, exp;
        int   busy_cnt, done_cnt, done_at;
        sb_q.push_back('{32'h0000_000C, 1'b0, 1'b0, 1'b0});
        start_op(32'd5, 32'd7, 1'b0);
        busy_cnt = 0; done_cnt = 0; done_at = 0; got = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin done_at = i; got = {soma, cout, ovf, zero}; end
            end
        end
        exp = sb_q.pop_front();
        total_cnt++;
        if (done_at - 1 !== 4) $display("FAIL add_latency: got=%0d required 4", done_at - 1);
        else pass_cnt++;
        total_cnt++;
        if (busy_cnt !== 5) $display("FAIL add_busy_len: got=%0d required 5", busy_cnt);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL add_done_pulses: got=%0d required 1", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (got !== exp) $display("FAIL add_result: got=%h required %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        exp_t got, exp;
        int   lat;
`ifdef ADD_SATURATE_EN
        sb_q.push_back('{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        sb_q.push_back('{32'h8000_0000, 1'b1, 1'b1, 1'b0});
`else
        sb_q.push_back('{32'h8000_0000, 1'b0, 1'b1, 1'b0});
        sb_q.push_back('{32'h0000_0000, 1'b1, 1'b1, 1'b1});
`endif
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(lat);
        got = {soma, cout, ovf, zero};
        exp = sb_q.pop_front();
        total_cnt++;
        if (got !== exp || lat !== 4)
            $display("FAIL ovf_pos: got=%h lat=%0d required %h lat=4", got, lat, exp);
        else pass_cnt++;
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(lat);
        got = {soma, cout, ovf, zero};
        exp = sb_q.pop_front();
        total_cnt++;
        if (got !== exp) $display("FAIL ovf_neg: got=%h required %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_carry_zero;
        exp_t got, exp;
        int   lat;
        sb_q.push_back('{32'h0000_0000, 1'b1, 1'b0, 1'b1});
        sb_q.push_back('{32'h0000_0000, 1'b1, 1'b0, 1'b1});
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(lat);
        got = {soma, cout, ovf, zero};
        exp = sb_q.pop_front();
        total_cnt++;
        if (got !== exp) $display("FAIL carry_wrap: got=%h required %h", got, exp);
        else pass_cnt++;
        start_op(32'd10, 32'd10, 1'b1);
        wait_done(lat);
        got = {soma, cout, ovf, zero};
        exp = sb_q.pop_front();
        total_cnt++;
        if (got !== exp) $display("FAIL sub_zero: got=%h required %h", got, exp);
        else pass_cnt++;
    endtask

    task automatic test_sub_ignore;
        exp_t got, exp;
        int   lat, busy_cnt;
        sb_q.push_back('{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        start_op(32'd3, 32'd5, 1'b1);
        @(posedge clk); #1;
        in1 = 32'h1111_0000; in2 = 32'h0000_2222; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in1 = 32'hDEAD_BEEF;
        wait_done(lat);
        got = {soma, cout, ovf, zero};
        exp = sb_q.pop_front();
        total_cnt++;
        if (got !== exp) $display("FAIL sub_neg_ignore: got=%h required %h", got, exp);
        else pass_cnt++;
        busy_cnt = 0;
        repeat (5) begin @(negedge clk); busy_cnt += int'(busy) + int'(done); end
        total_cnt++;
        if (busy_cnt !== 0) $display("FAIL busy_start_ignored: activity=%0d required 0", busy_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort;
        exp_t got, exp;
        int   lat;
        start_op(32'h0000_1234, 32'h0000_0001, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        got = {soma, cout, ovf, zero};
        total_cnt++;
        if (got !== 35'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_state: got=%h busy=%b done=%b required all 0", got, busy, done);
        else pass_cnt++;
        // An aborted op leaking a Done pulse would shorten the measured latency.
        sb_q.push_back('{32'h0000_1235, 1'b0, 1'b0, 1'b0});
        start_op(32'h0000_1234, 32'h0000_0001, 1'b0);
        wait_done(lat);
        got = {soma, cout, ovf, zero};
        exp = sb_q.pop_front();
        total_cnt++;
        if (got !== exp || lat !== 4)
            $display("FAIL after_abort: got=%h lat=%0d required %h lat=4", got, lat, exp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        exp_t        got, exp;
        int          lat;
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                a = corner_a[i]; b = corner_b[i]; s = corner_s[i];
            end else begin
                a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            end
            sb_q.push_back(model(a, b, s));
            start_op(a, b, s);
            wait_done(lat);
            got = {soma, cout, ovf, zero};
            exp = sb_q.pop_front();
            total_cnt++;
            if (got !== exp || lat !== 4)
                $display("FAIL b2b_%0d: a=%h b=%h sub=%b got=%h lat=%0d required %h lat=4",
                         i, a, b, s, got, lat, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_slice;
        logic [18:0] got;
        int          lat;
        @(posedge clk); #1;
        s_in1 = 16'h8000; s_in2 = 16'h8000; s_sub = 1'b0; s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            if (s_done) break;
            lat++;
        end
        got = {s_soma, s_cout, s_ovf, s_zero};
        total_cnt++;
        if (lat !== 1) $display("FAIL s16_latency: got=%0d required 1", lat);
        else pass_cnt++;
        total_cnt++;
`ifdef ADD_SATURATE_EN
        if (got !== {16'h8000, 1'b1, 1'b1, 1'b0})
            $display("FAIL s16_result: got=%h required %h", got, {16'h8000, 3'b110});
`else
        if (got !== {16'h0000, 1'b1, 1'b1, 1'b1})
            $display("FAIL s16_result: got=%h required %h", got, {16'h0000, 3'b111});
`endif
        else pass_cnt++;
        @(posedge clk); #1;
        s_in1 = 16'h0001; s_in2 = 16'h0002; s_sub = 1'b1; s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        repeat (2) @(negedge clk);
        got = {s_soma, s_cout, s_ovf, s_zero};
        total_cnt++;
        if (got !== {16'hFFFF, 3'b000} || s_done !== 1'b1)
            $display("FAIL s16_sub: got=%h done=%b required %h done=1", got, s_done,
                     {16'hFFFF, 3'b000});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_carry_zero();
        test_sub_ignore();
        test_reset_abort();
        test_back_to_back();
        test_single_slice();
        total_cnt++;
        if (sb_q.size() !== 0) $display("FAIL sb_empty: got=%0d required 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
